clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor_if.sv | 26 ++
 rtl/clk_div_monitor.sv | 152 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if -- bundles the monitor's data-plane signals.
//   master (stimulus side): drives clk_div_in, exp_period, exp_load, err_clr;
//                           observes period, period_valid, locked, err.
//   slave  (monitor side) : the mirror image.
interface clk_div_monitor_if #(
  parameter int WIDTH = 8
);
  logic             clk_div_in;
  logic [WIDTH-1:0] exp_period;
  logic             exp_load;
  logic             err_clr;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;

  modport master (
    output clk_div_in, exp_period, exp_load, err_clr,
    input  period, period_valid, locked, err
  );

  modport slave (
    input  clk_div_in, exp_period, exp_load, err_clr,
    output period, period_valid, locked, err
  );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor -- measures the period of a divided clock (sampled as data)
// in clk cycles, compares it to a loaded expectation and reports lock/error.
//   clk, rst         : single clock, async active-high reset
//   bus.clk_div_in   : divided clock under test
//   bus.exp_period   : expected period, captured on bus.exp_load
//   bus.exp_load     : strobe, loads expectation and restarts acquisition
//   bus.err_clr      : strobe, clears the sticky err flag
//   bus.period       : last measured period (pulses bus.period_valid)
//   bus.locked       : LOCK_N consecutive in-tolerance periods seen
//   bus.err          : sticky mismatch-while-locked / timeout flag
module clk_div_monitor #(
  parameter int WIDTH  = 8,
  parameter int LOCK_N = 4,
  parameter int TOL    = 0
) (
  input  logic               clk,
  input  logic               rst,
  clk_div_monitor_if.slave   bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH:0]   TOL_W   = (WIDTH+1)'(TOL);
  localparam logic [3:0]       LOCK_W  = 4'(LOCK_N);

  typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCKED} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic             pv_q, pv_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic             rise;
  logic             timeout;
  logic             match;
  logic [WIDTH:0]   diff;
  logic [3:0]       match_inc;

  // s1/s2 synchronise, s3 delays one more cycle for edge detection.
  assign rise      = s2_q & ~s3_q;
  assign timeout   = (cnt_q == CNT_MAX);
  assign diff      = ({1'b0, cnt_q} >= {1'b0, exp_q}) ? ({1'b0, cnt_q} - {1'b0, exp_q})
                                                      : ({1'b0, exp_q} - {1'b0, cnt_q});
  assign match     = (diff <= TOL_W);
  assign match_inc = match_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = rise ? WIDTH'(1) : (timeout ? cnt_q : cnt_q + WIDTH'(1));
    exp_d       = exp_q;
    period_d    = period_q;
    match_cnt_d = match_cnt_q;
    pv_d        = 1'b0;
    locked_d    = locked_q;
    // Clear first; any set below overrides it so a coincident set wins.
    err_d       = bus.err_clr ? 1'b0 : err_q;

    if (bus.exp_load) begin
      // Restart from a clean count so a stale saturated cnt cannot
      // immediately read as a timeout; a coincident rise is dropped.
      exp_d       = bus.exp_period;
      cnt_d       = '0;
      match_cnt_d = '0;
      locked_d    = 1'b0;
      state_d     = (bus.exp_period == '0) ? IDLE : ACQ;
    end else begin
      case (state_q)
        IDLE: ;
        ACQ: begin
          // First edge only aligns the counter; it wins over a timeout so
          // a resumed clock relocks after 1 + LOCK_N edges.
          if (rise) begin
            state_d = MEAS;
          end else if (timeout) begin
            err_d       = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            cnt_d       = '0;
          end
        end
        MEAS, LOCKED: begin
          if (timeout) begin
            // Restart cnt so each stall window reports one timeout.
            err_d       = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            cnt_d       = '0;
            state_d     = ACQ;
          end else if (rise) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            if (match) begin
              if (state_q == MEAS) begin
                match_cnt_d = match_inc;
                if (match_inc == LOCK_W) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                end
              end
            end else begin
              match_cnt_d = '0;
              if (state_q == LOCKED) begin
                err_d    = 1'b1;
                locked_d = 1'b0;
                state_d  = MEAS;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      exp_q       <= '0;
      period_q    <= '0;
      match_cnt_q <= '0;
      pv_q        <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= bus.clk_div_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      period_q    <= period_d;
      match_cnt_q <= match_cnt_d;
      pv_q        <= pv_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: dut0 (TOL=0) and dut1 (TOL=1), both WIDTH=8,
// LOCK_N=4. Stimulus pushes the expected {period, locked, err} for each
// period_valid it provokes; a negedge monitor pops and compares.
module tb_clk_div_monitor;

  typedef struct packed {
    logic [7:0] per;
    logic       lk;
    logic       er;
  } exp_t;

  logic clk;
  logic rst;

  clk_div_monitor_if #(.WIDTH(8)) b0 ();
  clk_div_monitor_if #(.WIDTH(8)) b1 ();

  clk_div_monitor #(.WIDTH(8), .LOCK_N(4), .TOL(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  clk_div_monitor #(.WIDTH(8), .LOCK_N(4), .TOL(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, expv);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (b0.period_valid === 1'b1) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL dut0_pv_unexpected: period %0d locked %0b err %0b with nothing queued",
                 b0.period, b0.locked, b0.err);
      end else begin
        e = q0.pop_front();
        chk("dut0_pv", {22'd0, b0.period, b0.locked, b0.err}, {22'd0, e});
      end
    end
    if (b1.period_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL dut1_pv_unexpected: period %0d locked %0b err %0b with nothing queued",
                 b1.period, b1.locked, b1.err);
      end else begin
        e = q1.pop_front();
        chk("dut1_pv", {22'd0, b1.period, b1.locked, b1.err}, {22'd0, e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input bit sel, input logic v);
    if (sel) b1.clk_div_in = v;
    else     b0.clk_div_in = v;
  endtask

  task automatic push(input bit sel, input logic [7:0] per, input logic lk, input logic er);
    exp_t e;
    e = '{per: per, lk: lk, er: er};
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  // One full cycle of the divided clock starting with its rising edge.
  task automatic wave(input bit sel, input int len);
    for (int i = 0; i < len; i++) begin
      drv(sel, (i < len / 2));
      cyc(1);
    end
  endtask

  task automatic load(input bit sel, input logic [7:0] v);
    if (sel) begin b1.exp_period = v; b1.exp_load = 1'b1; end
    else     begin b0.exp_period = v; b0.exp_load = 1'b1; end
    cyc(1);
    b0.exp_load = 1'b0;
    b1.exp_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b0.clk_div_in = 1'b0; b0.exp_period = '0; b0.exp_load = 1'b0; b0.err_clr = 1'b0;
    b1.clk_div_in = 1'b0; b1.exp_period = '0; b1.exp_load = 1'b0; b1.err_clr = 1'b0;
    cyc(3);
    chk("rst_period", {24'd0, b0.period}, 32'd0);
    chk("rst_pv",     {31'd0, b0.period_valid}, 32'd0);
    chk("rst_locked", {31'd0, b0.locked}, 32'd0);
    chk("rst_err",    {31'd0, b0.err}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // No exp_load yet: edges must produce nothing.
    wave(0, 8); wave(0, 8); wave(0, 8);

    // Lock at period 8.
    load(0, 8'd8);
    wave(0, 8);
    push(0, 8, 0, 0); wave(0, 8);
    push(0, 8, 0, 0); wave(0, 8);
    push(0, 8, 0, 0); wave(0, 8);
    push(0, 8, 1, 0); wave(0, 8);
    push(0, 8, 1, 0); wave(0, 10);
    // The 10-cycle period breaks lock and sets err; relock keeps err.
    push(0, 10, 0, 1); wave(0, 8);
    push(0, 8, 0, 1); wave(0, 8);
    push(0, 8, 0, 1); wave(0, 8);
    push(0, 8, 0, 1); wave(0, 8);
    push(0, 8, 1, 1); wave(0, 8);
    b0.err_clr = 1'b1; cyc(1); b0.err_clr = 1'b0;
    chk("errclr_err",    {31'd0, b0.err}, 32'd0);
    chk("errclr_locked", {31'd0, b0.locked}, 32'd1);

    // Stall: counter saturates, timeout drops lock and sets err.
    cyc(300);
    chk("timeout_err",    {31'd0, b0.err}, 32'd1);
    chk("timeout_locked", {31'd0, b0.locked}, 32'd0);
    wave(0, 8);
    push(0, 8, 0, 1); wave(0, 8);
    push(0, 8, 0, 1); wave(0, 8);
    push(0, 8, 0, 1); wave(0, 8);
    push(0, 8, 1, 1); wave(0, 8);

    // exp_load on the very cycle the rise is acted on: rise ignored.
    drv(0, 1'b1);
    cyc(2);
    load(0, 8'd8);
    chk("ldrise_locked", {31'd0, b0.locked}, 32'd0);
    cyc(1);
    drv(0, 1'b0);
    cyc(4);
    load(0, 8'd0);
    wave(0, 8); wave(0, 8); wave(0, 8);
    chk("zero_locked", {31'd0, b0.locked}, 32'd0);
    chk("zero_err",    {31'd0, b0.err}, 32'd1);

    // Async reset mid-MEAS.
    load(0, 8'd8);
    wave(0, 8);
    push(0, 8, 0, 1); wave(0, 8);
    push(0, 8, 0, 1); wave(0, 8);
    #2 rst = 1'b1;
    #1;
    chk("arst_period", {24'd0, b0.period}, 32'd0);
    chk("arst_pv",     {31'd0, b0.period_valid}, 32'd0);
    chk("arst_locked", {31'd0, b0.locked}, 32'd0);
    chk("arst_err",    {31'd0, b0.err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wave(0, 8); wave(0, 8); wave(0, 8);
    load(0, 8'd8);
    wave(0, 8);
    push(0, 8, 0, 0); wave(0, 8);
    push(0, 8, 0, 0); wave(0, 8);
    push(0, 8, 0, 0); wave(0, 8);
    push(0, 8, 1, 0); wave(0, 8);
    chk("relock_locked", {31'd0, b0.locked}, 32'd1);

    // TOL=1: alternating 7/9 periods still lock.
    load(1, 8'd8);
    wave(1, 7);
    push(1, 7, 0, 0); wave(1, 9);
    push(1, 9, 0, 0); wave(1, 7);
    push(1, 7, 0, 0); wave(1, 9);
    push(1, 9, 1, 0); wave(1, 7);
    chk("tol_locked", {31'd0, b1.locked}, 32'd1);
    chk("tol_err",    {31'd0, b1.err}, 32'd0);

    cyc(5);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
